ahb_master_requester: RTL

AHB_MASTER_REQUESTER -- requirements
Module: ahb_master_requester

---
 rtl/ahb_master_requester.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_master_requester.sv
// AHB burst requester: takes one transfer command at a time, requests the bus,
// drives the beat addresses of the burst and pulses done after the last data phase.
// A burst that loses its grant part-way is resumed as an INCR burst from the next beat.
module ahb_master_requester #(
   parameter int ADDR_W = 32
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_burst,
   input  logic              cmd_write,
   output logic              hreq,
   input  logic              hgrant,
   input  logic              hwait,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic [2:0]        hburst,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_LAST  = 2'd3;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [2:0] BURST_INCR = 3'd1;

   // Index of the final beat for a burst encoding (beat count minus one).
   function automatic logic [3:0] last_idx(input logic [2:0] burst);
      logic [3:0] idx;
      case (burst)
         3'd0, 3'd1: idx = 4'd0;
         3'd2, 3'd3: idx = 4'd3;
         3'd4, 3'd5: idx = 4'd7;
         3'd6, 3'd7: idx = 4'd15;
         default:    idx = 4'd0;
      endcase
      return idx;
   endfunction

   // Address of the following beat; WRAPn bursts only touch the bits inside the 4*n-byte block.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0]        burst);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] mask;
      logic [5:0]        m;
      case (burst)
         3'd2:    m = 6'h0F;
         3'd4:    m = 6'h1F;
         3'd6:    m = 6'h3F;
         default: m = 6'h00;
      endcase
      inc  = a + ADDR_W'(3'd4);
      mask = {{(ADDR_W-6){1'b0}}, m};
      if (m == 6'h00) begin
         return inc;
      end else begin
         return (a & ~mask) | (inc & mask);
      end
   endfunction

   logic [1:0]        state_r,  state_s;
   logic [3:0]        cnt_r,    cnt_s;
   logic [ADDR_W-1:0] addr_r,   addr_s;
   logic [2:0]        burst_r,  burst_s;
   logic              write_r,  write_s;
   logic              first_r,  first_s;
   logic              broken_r, broken_s;
   logic              hreq_r,   hreq_s;
   logic [1:0]        htrans_r, htrans_s;
   logic [2:0]        hburst_r, hburst_s;
   logic              done_r,   done_s;

   // Next-state, beat tracking and next values of every registered bus output.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      addr_s   = addr_r;
      burst_s  = burst_r;
      write_s  = write_r;
      first_s  = first_r;
      broken_s = broken_r;
      done_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_s   = cmd_addr;
               burst_s  = cmd_burst;
               write_s  = cmd_write;
               cnt_s    = 4'd0;
               first_s  = 1'b0;
               broken_s = 1'b0;
               state_s  = S_REQ;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (hgrant) begin
               first_s = 1'b1;
               state_s = S_BURST;
            end else begin
               state_s = S_REQ;
            end
         end
         S_BURST: begin
            if (!hwait) begin
               if (cnt_r == last_idx(burst_r)) begin
                  state_s = S_LAST;
               end else begin
                  cnt_s   = cnt_r + 4'd1;
                  addr_s  = next_addr(addr_r, burst_r);
                  first_s = 1'b0;
                  if (!hgrant) begin
                     // Grant lost: the rest of the burst restarts as NONSEQ/INCR.
                     broken_s = 1'b1;
                     state_s  = S_REQ;
                  end else begin
                     state_s = S_BURST;
                  end
               end
            end else begin
               state_s = S_BURST;
            end
         end
         S_LAST: begin
            if (!hwait) begin
               done_s  = 1'b1;
               state_s = S_IDLE;
            end else begin
               state_s = S_LAST;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      hreq_s = (state_s == S_REQ) ||
               ((state_s == S_BURST) && (cnt_s != last_idx(burst_s)));
      if (state_s == S_BURST) begin
         htrans_s = first_s ? TR_NONSEQ : TR_SEQ;
      end else begin
         htrans_s = TR_IDLE;
      end
      hburst_s = broken_s ? BURST_INCR : burst_s;
   end

   // State, beat context and bus-output registers; reset aborts any transfer at once.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_r  <= S_IDLE;
         cnt_r    <= 4'd0;
         addr_r   <= '0;
         burst_r  <= 3'd0;
         write_r  <= 1'b0;
         first_r  <= 1'b0;
         broken_r <= 1'b0;
         hreq_r   <= 1'b0;
         htrans_r <= TR_IDLE;
         hburst_r <= 3'd0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         addr_r   <= addr_s;
         burst_r  <= burst_s;
         write_r  <= write_s;
         first_r  <= first_s;
         broken_r <= broken_s;
         hreq_r   <= hreq_s;
         htrans_r <= htrans_s;
         hburst_r <= hburst_s;
         done_r   <= done_s;
      end
   end

   assign cmd_ready = (state_r == S_IDLE) && !hreset;
   assign hreq      = hreq_r;
   assign haddr     = addr_r;
   assign htrans    = htrans_r;
   assign hburst    = hburst_r;
   assign hwrite    = write_r;
   assign hsize     = 3'b010;
   assign done      = done_r;

endmodule
